rr_req_arbiter: RTL and testbench

RR_REQ_ARBITER -- requirements
Module: rr_req_arbiter

---
 rtl/rr_req_arbiter.sv | 143 ++++++++++++++
 tb/tb_rr_req_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_req_arbiter.sv
// Round-robin request arbiter with a bounded grant tenure (time slice) and a one-cycle release gap.
// Defining RR_ARB_LOCK_EN adds an i_lock input that lets the owner run past slice expiry.
module rr_req_arbiter #(
    parameter int N_REQ        = 8,
    parameter int IDX_W        = 4,
    parameter int SLICE_CYCLES = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_done,
`ifdef RR_ARB_LOCK_EN
    input  logic             i_lock,
`endif
    output logic [N_REQ-1:0] o_grant,
    output logic [IDX_W-1:0] o_grant_idx,
    output logic             o_grant_valid
);

    localparam int               CNT_W    = $clog2(SLICE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLICE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RELEASE
    } state_t;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             rst_sync_n;
    logic             lock_active;
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic             owner_req;
    logic             others_req;
    logic             slice_end;
    logic             release_now;

    // Assertion is immediate; deassertion waits for one rising edge.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) rst_sync_n <= 1'b0;
        else          rst_sync_n <= 1'b1;
    end

`ifdef RR_ARB_LOCK_EN
    assign lock_active = i_lock;
`else
    assign lock_active = 1'b0;
`endif

    // Scan from the highest offset down so the nearest request at or after the pointer wins.
    always_comb begin
        int cand;
        cand      = 0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            cand = int'(ptr_q) + off;
            if (cand >= N_REQ) cand = cand - N_REQ;
            if ((i_req & (N_REQ'(1) << cand)) != '0) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(cand);
            end
        end
    end

    assign owner_req   = |(i_req & grant_q);
    assign others_req  = |(i_req & ~grant_q);
    assign slice_end   = (cnt_q == CNT_LAST);
    assign release_now = i_done | ~owner_req | (slice_end & others_req & ~lock_active);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, RELEASE: begin
                if (sel_found) begin
                    state_d = GRANT;
                    grant_d = N_REQ'(1) << sel_idx;
                    idx_d   = sel_idx;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                    valid_d = 1'b0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_d = RELEASE;
                    grant_d = '0;
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    ptr_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                end else if (!slice_end) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (!lock_active) begin
                    cnt_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_grant       = grant_q;
    assign o_grant_idx   = idx_q;
    assign o_grant_valid = valid_q;

endmodule

// File: tb/tb_rr_req_arbiter.sv
// Self-checking bench for rr_req_arbiter: directed vector table, hand-written corner sequences
// and randomized traffic against a behavioural model. Define RR_ARB_LOCK_EN to cover i_lock.
module tb_rr_req_arbiter;

    localparam int N_REQ        = 8;
    localparam int IDX_W        = 4;
    localparam int SLICE_CYCLES = 16;

    logic       i_clk    = 1'b0;
    logic       i_reset  = 1'b0;
    logic [7:0] i_req    = '0;
    logic       i_done   = 1'b0;
    logic       lock_drv = 1'b0;
    logic [7:0] o_grant;
    logic [3:0] o_grant_idx;
    logic       o_grant_valid;

    int tests_run    = 0;
    int tests_failed = 0;

    int m_owner;
    int m_last;
    int m_ptr;
    int m_tenure;

    typedef struct {
        bit         do_reset;
        logic [7:0] req;
        logic       done;
        logic       lock;
        int         cycles;
        logic       exp_valid;
        logic [3:0] exp_idx;
    } vec_t;

    vec_t vecs[$];

    always #5 i_clk = ~i_clk;

    rr_req_arbiter #(
        .N_REQ       (N_REQ),
        .IDX_W       (IDX_W),
        .SLICE_CYCLES(SLICE_CYCLES)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_req        (i_req),
        .i_done       (i_done),
`ifdef RR_ARB_LOCK_EN
        .i_lock       (lock_drv),
`endif
        .o_grant      (o_grant),
        .o_grant_idx  (o_grant_idx),
        .o_grant_valid(o_grant_valid)
    );

    function automatic logic [7:0] onehot(input logic valid, input logic [3:0] idx);
        logic [7:0] one;
        one = 8'h01;
        return valid ? (one << idx) : 8'h00;
    endfunction

    function automatic void add(input bit rst, input logic [7:0] req, input logic done,
                                input logic lock, input int cyc, input logic v,
                                input logic [3:0] idx);
        vec_t e;
        e.do_reset  = rst;
        e.req       = req;
        e.done      = done;
        e.lock      = lock;
        e.cycles    = cyc;
        e.exp_valid = v;
        e.exp_idx   = idx;
        vecs.push_back(e);
    endfunction

    task automatic checkOutput(input string name, input logic exp_valid, input logic [3:0] exp_idx);
        logic [7:0] exp_grant;
        exp_grant = onehot(exp_valid, exp_idx);
        tests_run++;
        if (o_grant_valid !== exp_valid) begin
            tests_failed++;
            $display("[TB] FAIL %s valid: got %0b, want %0b", name, o_grant_valid, exp_valid);
        end
        tests_run++;
        if (o_grant_idx !== exp_idx) begin
            tests_failed++;
            $display("[TB] FAIL %s idx: got %0d, want %0d", name, o_grant_idx, exp_idx);
        end
        tests_run++;
        if (o_grant !== exp_grant) begin
            tests_failed++;
            $display("[TB] FAIL %s grant: got %b, want %b", name, o_grant, exp_grant);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the last rising edge.
    task automatic applyStimulus(input logic [7:0] req, input logic done, input logic lock,
                                 input int cycles);
        i_req    = req;
        i_done   = done;
        lock_drv = lock;
        repeat (cycles) @(posedge i_clk);
        @(negedge i_clk);
    endtask

    // Leaves the arbiter idle with the reset synchroniser already released.
    task automatic doReset();
        i_reset  = 1'b0;
        i_req    = '0;
        i_done   = 1'b0;
        lock_drv = 1'b0;
        @(negedge i_clk);
        checkOutput("reset", 1'b0, 4'd0);
        i_reset = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    function automatic int pick(input logic [7:0] req, input int ptr);
        int k;
        for (int off = 0; off < N_REQ; off++) begin
            k = (ptr + off) % N_REQ;
            if (((req >> k) & 8'h01) != 8'h00) return k;
        end
        return -1;
    endfunction

    // One rising edge of the arbiter's behaviour as stated by its rules.
    task automatic model_step(input logic [7:0] req, input logic done, input logic lock);
        int  p;
        bit  mine;
        bit  others;
        logic [7:0] one;
        one = 8'h01;
        if (m_owner >= 0) begin
            mine   = ((req >> m_owner) & 8'h01) != 8'h00;
            others = (req & ~(one << m_owner)) != 8'h00;
            if (done || !mine || (m_tenure == SLICE_CYCLES - 1 && others && !lock)) begin
                m_ptr   = (m_owner + 1) % N_REQ;
                m_owner = -1;
            end else if (m_tenure < SLICE_CYCLES - 1) begin
                m_tenure++;
            end else if (!lock) begin
                m_tenure = 0;
            end
        end else begin
            p = pick(req, m_ptr);
            if (p >= 0) begin
                m_owner  = p;
                m_last   = p;
                m_tenure = 0;
            end
        end
    endtask

    initial begin
        logic [7:0] cur_req;
        int         hold;

        // Two requesters sharing by slice expiry, then rotation back to 0.
        add(1, 8'h05, 0, 0, 1,  1, 0);
        add(0, 8'h05, 0, 0, 14, 1, 0);
        add(0, 8'h05, 0, 0, 1,  1, 0);
        add(0, 8'h05, 0, 0, 1,  0, 0);
        add(0, 8'h05, 0, 0, 1,  1, 2);
        add(0, 8'h05, 0, 0, 15, 1, 2);
        add(0, 8'h05, 0, 0, 1,  0, 2);
        add(0, 8'h05, 0, 0, 1,  1, 0);
        // Early release by i_done from owner 5, then full tenures wrapping 7 -> 0.
        add(1, 8'h20, 0, 0, 1,  1, 5);
        add(0, 8'hFF, 0, 0, 2,  1, 5);
        add(0, 8'hFF, 1, 0, 1,  0, 5);
        add(0, 8'hFF, 0, 0, 1,  1, 6);
        add(0, 8'hFF, 0, 0, 15, 1, 6);
        add(0, 8'hFF, 0, 0, 1,  0, 6);
        add(0, 8'hFF, 0, 0, 1,  1, 7);
        add(0, 8'hFF, 0, 0, 15, 1, 7);
        add(0, 8'hFF, 0, 0, 1,  0, 7);
        add(0, 8'hFF, 0, 0, 1,  1, 0);
        // i_done together with slice expiry: one release, pointer lands on 2.
        add(1, 8'h02, 0, 0, 1,  1, 1);
        add(0, 8'h0B, 0, 0, 14, 1, 1);
        add(0, 8'h0B, 0, 0, 1,  1, 1);
        add(0, 8'h0B, 1, 0, 1,  0, 1);
        add(0, 8'h0B, 0, 0, 1,  1, 3);
        add(0, 8'h0B, 0, 0, 15, 1, 3);
        add(0, 8'h0B, 0, 0, 1,  0, 3);
        add(0, 8'h0B, 0, 0, 1,  1, 0);
        // i_done while idle is ignored; a waiting requester dropping out changes nothing.
        add(1, 8'h00, 1, 0, 2,  0, 0);
        add(1, 8'h06, 0, 0, 1,  1, 1);
        add(0, 8'h02, 0, 0, 20, 1, 1);
`ifdef RR_ARB_LOCK_EN
        add(1, 8'h03, 0, 1, 1,  1, 0);
        add(0, 8'h03, 0, 1, 20, 1, 0);
        add(0, 8'h03, 0, 0, 1,  0, 0);
        add(0, 8'h03, 0, 0, 1,  1, 1);
`endif

        foreach (vecs[i]) begin
            if (vecs[i].do_reset) doReset();
            applyStimulus(vecs[i].req, vecs[i].done, vecs[i].lock, vecs[i].cycles);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_idx);
        end

        // Lone requester keeps its grant across several slice boundaries.
        doReset();
        applyStimulus(8'h08, 0, 0, 1);
        checkOutput("solo_first", 1'b1, 4'd3);
        for (int c = 0; c < 40; c++) begin
            applyStimulus(8'h08, 0, 0, 1);
            checkOutput($sformatf("solo_hold%0d", c), 1'b1, 4'd3);
        end

        // Reset asserted mid-tenure clears outputs between clock edges.
        doReset();
        applyStimulus(8'h10, 0, 0, 1);
        checkOutput("mid_grant", 1'b1, 4'd4);
        applyStimulus(8'h10, 0, 0, 5);
        #2 i_reset = 1'b0;
        #1 checkOutput("mid_async", 1'b0, 4'd0);
        @(negedge i_clk);
        i_reset = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        checkOutput("mid_sync", 1'b0, 4'd0);
        applyStimulus(8'h10, 0, 0, 1);
        checkOutput("mid_regrant", 1'b1, 4'd4);

        // Randomized traffic against the model.
        doReset();
        m_owner  = -1;
        m_last   = 0;
        m_ptr    = 0;
        m_tenure = 0;
        hold     = 0;
        cur_req  = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (hold == 0) begin
                case ($urandom_range(0, 3))
                    0:       cur_req = 8'h00;
                    1:       cur_req = 8'h01 << $urandom_range(0, 7);
                    2:       cur_req = 8'($urandom) & 8'($urandom);
                    default: cur_req = 8'($urandom);
                endcase
                hold = $urandom_range(1, 40);
            end
            hold--;
            i_req  = cur_req;
            i_done = ($urandom_range(0, 31) == 0);
`ifdef RR_ARB_LOCK_EN
            if ($urandom_range(0, 15) == 0) lock_drv = ~lock_drv;
`endif
            @(posedge i_clk);
            model_step(i_req, i_done, lock_drv);
            @(negedge i_clk);
            checkOutput($sformatf("rand%0d", cyc), m_owner >= 0, 4'(m_last));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
